// File: rtl/ctrl_fsm_gen2_pkg.sv
// ctrl_fsm_gen2_pkg: opcodes, misc subcodes and state encodings shared by the control unit
package ctrl_fsm_gen2_pkg;
  localparam logic [2:0] S_FETCH = 3'd0, S_OPERAND = 3'd1, S_MEM_WAIT = 3'd2, S_RET_WAIT = 3'd3,
                         S_SKIP = 3'd4, S_SKIP2 = 3'd5, S_FAULT = 3'd6;
  localparam logic [3:0] OP_LD = 4'h8, OP_JMP = 4'h9, OP_CALL = 4'hA, OP_MISC = 4'hB,
                         OP_IEQ = 4'hC, OP_INE = 4'hD, OP_ST = 4'hE, OP_LDUM = 4'hF;
  localparam logic [3:0] SUB_RTS = 4'h0, SUB_STSP = 4'h1, SUB_POP = 4'h2, SUB_RTI = 4'h3,
                         SUB_LDSP = 4'h4, SUB_EI = 4'h5, SUB_DI = 4'h6, SUB_PUSH = 4'h8;
  function automatic logic two_word(input logic [3:0] op);
    return op == OP_LD || op == OP_ST || op == OP_LDUM;
  endfunction
endpackage

// File: rtl/ctrl_fsm_gen2_sp.sv
// ctrl_fsm_gen2_sp: stack pointer with push/pop/load, bound flags and stack slot addressing
module ctrl_fsm_gen2_sp
  import ctrl_fsm_gen2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_BASE  = 'hC0,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  output logic [SP_W-1:0]   sp_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              load_bad_o,
  output logic [ADDR_W-1:0] push_addr_o,
  output logic [ADDR_W-1:0] pop_addr_o
);
  logic [SP_W-1:0] sp_q, sp_d;
  assign sp_o        = sp_q;
  assign full_o      = 32'(sp_q) == STACK_DEPTH;
  assign empty_o     = sp_q == '0;
  assign load_bad_o  = 32'(load_val_i) > STACK_DEPTH;
  assign pop_addr_o  = ADDR_W'(STACK_BASE + 32'(sp_q));
  assign push_addr_o = ADDR_W'(STACK_BASE + 32'(sp_q) + 1);
  // next sp: an explicit load wins over push, push over pop
  always_comb sp_d = load_i ? SP_W'(load_val_i) : push_i ? sp_q + SP_W'(1) : pop_i ? sp_q - SP_W'(1) : sp_q;
  // stack pointer register, empty after reset
  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else sp_q <= sp_d;
  end
endmodule

// File: rtl/ctrl_fsm_gen2.sv
// ctrl_fsm_gen2: multicycle control unit decoding program words into regfile/ALU/user-memory/PC controls
module ctrl_fsm_gen2
  import ctrl_fsm_gen2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int RSEL_W      = 2,
  parameter int STACK_BASE  = 'hC0,
  parameter int STACK_DEPTH = 16,
  parameter int RESET_VEC   = 0,
  parameter int IRQ_VEC     = 'hFD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               irq,
  input  logic [DATA_W-1:0]                  pm_data,
  input  logic [ADDR_W-1:0]                  pm_addr,
  input  logic [DATA_W-1:0]                  rf_rdata1,
  input  logic [DATA_W-1:0]                  rf_rdata2,
  input  logic [DATA_W-1:0]                  alu_result,
  input  logic [DATA_W-1:0]                  um_rdata,
  output logic [3:0]                         alu_op,
  output logic [RSEL_W-1:0]                  rf_rsel1,
  output logic [RSEL_W-1:0]                  rf_rsel2,
  output logic [RSEL_W-1:0]                  rf_wsel,
  output logic                               rf_we,
  output logic [DATA_W-1:0]                  rf_wdata,
  output logic [ADDR_W-1:0]                  um_addr,
  output logic [DATA_W-1:0]                  um_wdata,
  output logic                               um_we,
  output logic                               pc_jump,
  output logic [ADDR_W-1:0]                  pc_target,
  output logic                               pc_freeze,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_out,
  output logic                               ie,
  output logic                               fault
);
  localparam int OPL = 4 + 2 * RSEL_W - 1;
  logic [2:0] state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d, instr, push_val;
  logic ie_q, ie_d, fault_q, fault_d, push_req, push, pop, load, full, empty, load_bad;
  logic [3:0] op, sub;
  logic [ADDR_W-1:0] push_addr, pop_addr;
  assign instr    = state_q == S_FETCH ? pm_data : ir_q;
  assign op       = instr[OPL -: 4];
  assign sub      = instr[3:0];
  assign alu_op   = op;
  assign rf_rsel1 = instr[2*RSEL_W-1 -: RSEL_W];
  assign rf_rsel2 = instr[RSEL_W-1:0];
  assign rf_wsel  = rf_rsel2;
  assign ie       = ie_q;
  assign fault    = fault_q;
  ctrl_fsm_gen2_sp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_BASE(STACK_BASE), .STACK_DEPTH(STACK_DEPTH)
  ) u_sp (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .load_i(load), .load_val_i(rf_rdata1),
    .sp_o(sp_out), .full_o(full), .empty_o(empty), .load_bad_o(load_bad),
    .push_addr_o(push_addr), .pop_addr_o(pop_addr)
  );
  // decode, sequencing and stack traffic; a push is resolved after decode so overflow can cancel it
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ie_d      = ie_q;
    fault_d   = fault_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_result;
    um_we     = 1'b0;
    um_addr   = pop_addr;
    um_wdata  = rf_rdata1;
    pc_jump   = 1'b0;
    pc_target = ADDR_W'(RESET_VEC);
    pc_freeze = 1'b0;
    push_req  = 1'b0;
    push_val  = rf_rdata1;
    push      = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d = pm_data;
        if (irq && ie_q) begin
          push_req  = 1'b1;
          push_val  = DATA_W'(pm_addr);
          ie_d      = 1'b0;
          pc_jump   = 1'b1;
          pc_target = ADDR_W'(IRQ_VEC);
        end else if (!op[3]) rf_we = 1'b1;
        else case (op)
          OP_LD, OP_ST, OP_LDUM: state_d = S_OPERAND;
          OP_JMP: begin
            pc_jump   = 1'b1;
            pc_target = rf_rdata2[ADDR_W-1:0];
          end
          OP_CALL: begin
            push_req  = 1'b1;
            push_val  = DATA_W'(pm_addr + ADDR_W'(1));
            pc_jump   = 1'b1;
            pc_target = rf_rdata2[ADDR_W-1:0];
          end
          OP_MISC: case (sub)
            SUB_RTS, SUB_RTI, SUB_POP: begin
              if (empty) begin
                fault_d = 1'b1;
                state_d = S_FAULT;
              end else begin
                pop     = 1'b1;
                state_d = sub == SUB_POP ? S_MEM_WAIT : S_RET_WAIT;
              end
            end
            SUB_STSP: begin
              rf_we    = 1'b1;
              rf_wdata = DATA_W'(sp_out);
            end
            SUB_LDSP: begin
              load    = !load_bad;
              fault_d = fault_q | load_bad;
              state_d = load_bad ? S_FAULT : S_FETCH;
            end
            SUB_EI: ie_d = 1'b1;
            SUB_DI: ie_d = 1'b0;
            SUB_PUSH: push_req = 1'b1;
            default: ;
          endcase
          OP_IEQ: state_d = rf_rdata1 != rf_rdata2 ? S_SKIP : S_FETCH;
          OP_INE: state_d = rf_rdata1 == rf_rdata2 ? S_SKIP : S_FETCH;
          default: ;
        endcase
      end
      S_OPERAND: begin
        state_d = op == OP_LDUM ? S_MEM_WAIT : S_FETCH;
        um_addr = pm_data[ADDR_W-1:0];
        um_we   = op == OP_ST;
        rf_we   = op == OP_LD;
        rf_wdata = pm_data;
      end
      S_MEM_WAIT: begin
        pc_freeze = 1'b1;
        rf_we     = 1'b1;
        rf_wdata  = um_rdata;
        state_d   = S_FETCH;
      end
      S_RET_WAIT: begin
        pc_jump   = 1'b1;
        pc_target = um_rdata[ADDR_W-1:0];
        ie_d      = sub == SUB_RTI ? 1'b1 : ie_q;
        state_d   = S_FETCH;
      end
      S_SKIP: state_d = two_word(pm_data[OPL -: 4]) ? S_SKIP2 : S_FETCH;
      S_SKIP2: state_d = S_FETCH;
      default: pc_freeze = 1'b1;
    endcase
    if (push_req && full) begin
      fault_d = 1'b1;
      state_d = S_FAULT;
      pc_jump = 1'b0;
    end else if (push_req) begin
      push     = 1'b1;
      um_we    = 1'b1;
      um_addr  = push_addr;
      um_wdata = push_val;
    end
    if (reset) begin
      pc_jump   = 1'b1;
      pc_target = ADDR_W'(RESET_VEC);
      pc_freeze = 1'b0;
      rf_we     = 1'b0;
      um_we     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
    end
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      ie_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ie_q    <= ie_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_ctrl_fsm_gen2.sv
// tb_ctrl_fsm_gen2: table-driven decode vectors plus multi-cycle sequences around a small CPU model
module tb_ctrl_fsm_gen2;
  logic clk = 1'b0, reset = 1'b1, irq = 1'b0, ovr = 1'b0;
  logic [7:0] ovr_word = 8'h00;
  logic [7:0] pm_data, pc, rf_rdata1, rf_rdata2, alu_result, um_rdata;
  logic [3:0] alu_op;
  logic [1:0] rf_rsel1, rf_rsel2, rf_wsel;
  logic rf_we, um_we, pc_jump, pc_freeze, ie, fault;
  logic [7:0] rf_wdata, um_addr, um_wdata, pc_target;
  logic [4:0] sp_out;
  logic [7:0] prog [256];
  logic [7:0] umem [256];
  logic [7:0] regs [4];
  logic [7:0] reg_init [4];
  int checks = 0, failures = 0;

  typedef struct {
    logic [7:0] word;
    logic       we;
    logic [7:0] wd;
    logic [1:0] ws;
    logic       uwe;
    logic [7:0] ua;
    logic [7:0] ud;
    logic       pj;
    logic [7:0] pt;
    logic       nf;
    logic       nie;
    logic [4:0] nsp;
  } vec_t;
  vec_t vecs [14];

  ctrl_fsm_gen2 dut (
    .clk(clk), .reset(reset), .irq(irq), .pm_data(pm_data), .pm_addr(pc),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_result(alu_result), .um_rdata(um_rdata),
    .alu_op(alu_op), .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2), .rf_wsel(rf_wsel),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .um_addr(um_addr), .um_wdata(um_wdata), .um_we(um_we),
    .pc_jump(pc_jump), .pc_target(pc_target), .pc_freeze(pc_freeze),
    .sp_out(sp_out), .ie(ie), .fault(fault)
  );

  always #5 clk = ~clk;

  assign pm_data    = ovr ? ovr_word : prog[pc];
  assign rf_rdata1  = regs[rf_rsel1];
  assign rf_rdata2  = regs[rf_rsel2];
  assign alu_result = alu_op == 4'd0 ? rf_rdata1 + rf_rdata2 : alu_op == 4'd1 ? rf_rdata1 - rf_rdata2 : rf_rdata1 ^ rf_rdata2;

  always @(posedge clk) pc <= pc_jump ? pc_target : pc_freeze ? pc : pc + 8'd1;

  always @(posedge clk) begin
    if (um_we) umem[um_addr] <= um_wdata;
    um_rdata <= umem[um_addr];
  end

  always @(posedge clk) begin
    if (reset) for (int k = 0; k < 4; k++) regs[k] <= reg_init[k];
    else if (rf_we) regs[rf_wsel] <= rf_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic boot();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) prog[k] = 8'hB7;
  endtask

  function automatic logic [63:0] pk(input logic we, input logic [7:0] wd, input logic [1:0] ws,
                                     input logic uwe, input logic [7:0] ua, input logic [7:0] ud,
                                     input logic pj, input logic [7:0] pt);
    return {27'b0, we, we ? wd : 8'h00, we ? ws : 2'b00, uwe, uwe ? ua : 8'h00, uwe ? ud : 8'h00, pj, pj ? pt : 8'h00};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reg_init[0] = 8'h05; reg_init[1] = 8'h10; reg_init[2] = 8'h34; reg_init[3] = 8'h40;
    vecs[0]  = '{8'h06, 1'b1, 8'h44, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{8'h1B, 1'b1, 8'hF4, 2'd3, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{8'h2D, 1'b1, 8'h50, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[3]  = '{8'h93, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{8'hA3, 1'b0, 8'h00, 2'd0, 1'b1, 8'hC1, 8'h01, 1'b1, 8'h40, 1'b0, 1'b0, 5'd1};
    vecs[5]  = '{8'hB8, 1'b0, 8'h00, 2'd0, 1'b1, 8'hC1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
    vecs[6]  = '{8'hB1, 1'b1, 8'h00, 2'd1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{8'hB5, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
    vecs[8]  = '{8'hC6, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[9]  = '{8'h81, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{8'hB2, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0};
    vecs[11] = '{8'hB7, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[12] = '{8'hB4, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd16};
    vecs[13] = '{8'hD5, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    clear_prog();
    #3;
    chk("reset_outputs", 64'({pc_jump, pc_target, rf_we, um_we, pc_freeze}), 64'({1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
    step();
    reset = 1'b0;
    #2;
    chk("reset_state", 64'({sp_out, ie, fault}), 64'({5'd0, 1'b0, 1'b0}));
    step();

    ovr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      ovr_word = vecs[i].word;
      boot();
      #2;
      chk($sformatf("vec%0d_out", i), pk(rf_we, rf_wdata, rf_wsel, um_we, um_addr, um_wdata, pc_jump, pc_target),
          pk(vecs[i].we, vecs[i].wd, vecs[i].ws, vecs[i].uwe, vecs[i].ua, vecs[i].ud, vecs[i].pj, vecs[i].pt));
      step();
      #2;
      chk($sformatf("vec%0d_next", i), 64'({fault, ie, sp_out}), 64'({vecs[i].nf, vecs[i].nie, vecs[i].nsp}));
    end
    ovr = 1'b0;

    for (int k = 0; k < 17; k++) prog[k] = 8'hB8;
    boot();
    for (int i = 0; i < 17; i++) begin
      #2;
      if (i < 16) chk($sformatf("push%0d", i), 64'({um_we, um_addr, um_wdata}), 64'({1'b1, 8'(8'hC1 + i), 8'h34}));
      else chk("push_overflow_we", 64'(um_we), 64'(1'b0));
      step();
    end
    #2;
    chk("overflow_fault", 64'({fault, pc_freeze, sp_out, um_we}), 64'({1'b1, 1'b1, 5'd16, 1'b0}));
    step(); step(); step();
    #2;
    chk("fault_hold", 64'({pc, pc_freeze, fault}), 64'({8'h11, 1'b1, 1'b1}));
    boot();
    #2;
    chk("fault_cleared", 64'({fault, sp_out, pc_freeze}), 64'({1'b0, 5'd0, 1'b0}));

    clear_prog();
    prog[0] = 8'hE4; prog[1] = 8'h80; prog[2] = 8'hF2; prog[3] = 8'h80;
    boot();
    #2;
    chk("st_fetch", 64'(um_we), 64'(1'b0));
    step(); #2;
    chk("st_operand", 64'({um_we, um_addr, um_wdata}), 64'({1'b1, 8'h80, 8'h10}));
    step(); step(); #2;
    chk("ldum_operand", 64'({um_we, rf_we, um_addr}), 64'({1'b0, 1'b0, 8'h80}));
    step(); #2;
    chk("ldum_memwait", 64'({pc_freeze, rf_we, rf_wdata, rf_wsel}), 64'({1'b1, 1'b1, 8'h10, 2'd2}));
    step(); #2;
    chk("ldum_result", 64'({regs[2], pc}), 64'({8'h10, 8'h04}));
    boot();
    step(); step(); step(); step();
    reset = 1'b1;
    #2;
    chk("reset_in_memwait", 64'({pc_jump, pc_target, rf_we, pc_freeze}), 64'({1'b1, 8'h00, 1'b0, 1'b0}));
    step();
    reset = 1'b0;
    #2;
    chk("after_reset", 64'({pc, sp_out, ie, um_we, pc_freeze}), 64'({8'h00, 5'd0, 1'b0, 1'b0, 1'b0}));
    step(); #2;
    chk("after_reset_operand", 64'({um_we, um_addr}), 64'({1'b1, 8'h80}));

    clear_prog();
    prog[0] = 8'h91; prog[8'h10] = 8'hA3; prog[8'h40] = 8'hB0;
    boot();
    step(); #2;
    chk("call", 64'({pc, um_we, um_addr, um_wdata, pc_jump, pc_target}), 64'({8'h10, 1'b1, 8'hC1, 8'h11, 1'b1, 8'h40}));
    step(); #2;
    chk("rts_fetch", 64'({pc, sp_out, um_we, um_addr}), 64'({8'h40, 5'd1, 1'b0, 8'hC1}));
    step(); #2;
    chk("rts_wait", 64'({sp_out, pc_jump, pc_target}), 64'({5'd0, 1'b1, 8'h11}));
    step(); #2;
    chk("rts_return", 64'(pc), 64'(8'h11));

    clear_prog();
    reg_init[2] = 8'h22;
    prog[0] = 8'hB5; prog[1] = 8'h92; prog[8'hFD] = 8'hB3;
    boot();
    step(); #2;
    chk("ei", 64'(ie), 64'(1'b1));
    step();
    irq = 1'b1;
    #2;
    chk("irq_entry", 64'({pc, um_we, um_addr, um_wdata, pc_jump, pc_target}), 64'({8'h22, 1'b1, 8'hC1, 8'h22, 1'b1, 8'hFD}));
    step(); #2;
    chk("irq_masked", 64'({pc, ie, sp_out, um_we, pc_jump}), 64'({8'hFD, 1'b0, 5'd1, 1'b0, 1'b0}));
    step();
    irq = 1'b0;
    #2;
    chk("rti_wait", 64'({pc_jump, pc_target}), 64'({1'b1, 8'h22}));
    step(); #2;
    chk("rti_return", 64'({pc, ie, sp_out}), 64'({8'h22, 1'b1, 5'd0}));
    reg_init[2] = 8'h34;

    clear_prog();
    prog[0] = 8'hC6; prog[1] = 8'h83; prog[2] = 8'h55;
    boot();
    step(); step(); step(); #2;
    chk("ieq_skip", 64'({pc, regs[3]}), 64'({8'h03, 8'h40}));
    reg_init[2] = 8'h10;
    boot();
    step(); step(); step(); #2;
    chk("ieq_noskip", 64'({pc, regs[3]}), 64'({8'h03, 8'h55}));
    reg_init[2] = 8'h34;

    clear_prog();
    prog[0] = 8'h05; prog[1] = 8'hB4;
    boot();
    step(); step(); #2;
    chk("ldsp_overflow", 64'({fault, sp_out, pc_freeze}), 64'({1'b1, 5'd0, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
